// File: rtl/controlador_menu_pkg.sv
// Shared definitions for the configuration menu: page encodings, cursor width
// and the one-hot to index helper used when a page's cursor is loaded.
package controlador_menu_pkg;

    localparam int CURSOR_W = 4;

    // Page encodings, also consumed by the game control unit.
    localparam logic [2:0] PAG_OCIOSO  = 3'd0;
    localparam logic [2:0] PAG_MODO    = 3'd1;
    localparam logic [2:0] PAG_BPM     = 3'd2;
    localparam logic [2:0] PAG_TOM     = 3'd3;
    localparam logic [2:0] PAG_MUSICA  = 3'd4;
    localparam logic [2:0] PAG_PRONTO  = 3'd5;

    typedef enum logic [2:0] {
        OCIOSO      = PAG_OCIOSO,
        MENU_MODO   = PAG_MODO,
        MENU_BPM    = PAG_BPM,
        MENU_TOM    = PAG_TOM,
        MENU_MUSICA = PAG_MUSICA,
        PRONTO      = PAG_PRONTO
    } estado_t;

    // Index of the lowest set bit; registers are kept one-hot so this is exact.
    function automatic logic [CURSOR_W-1:0] onehot_para_indice(input logic [15:0] v);
        logic [CURSOR_W-1:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = CURSOR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/controlador_menu_detector_borda.sv
// 1-bit rising-edge detector: one event per low-to-high transition of a level.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic in_i,
    output logic borda_o
);

    logic in_q;

    // Remember the previous level so a held input fires only once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) in_q <= 1'b0;
        else       in_q <= in_i;
    end

    assign borda_o = in_i & ~in_q;

endmodule

// File: rtl/controlador_menu.sv
// Configuration-menu sequencer: walks mode, BPM, tone and song pages with a
// wrapping cursor and commits each choice into a one-hot register.
module controlador_menu
    import controlador_menu_pkg::*;
#(
    parameter int              MODO             = 6,
    parameter int              BPM              = 2,
    parameter int              TOM              = 4,
    parameter int              MUSICA           = 16,
    parameter logic [MODO-1:0] MODOS_SEM_MUSICA = 6'b100000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar_menu,
    input  logic              right_arrow_pressed,
    input  logic              left_arrow_pressed,
    input  logic              enter_pressed,
    output logic [2:0]        menu_sel,
    output logic              mostra_menu,
    output logic [3:0]        arduino_out,
    output logic [MODO-1:0]   modos,
    output logic [BPM-1:0]    bpm,
    output logic [TOM-1:0]    tom,
    output logic [MUSICA-1:0] musica,
    output logic              config_pronta
);

    // Bit order: 0 iniciar, 1 right, 2 left, 3 enter.
    logic [3:0] teclas;
    logic [3:0] eventos;

    assign teclas = {enter_pressed, left_arrow_pressed, right_arrow_pressed, iniciar_menu};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_borda
            detector_borda u_borda (
                .clock   (clock),
                .reset   (reset),
                .in_i    (teclas[gi]),
                .borda_o (eventos[gi])
            );
        end
    endgenerate

    logic ev_ini, ev_dir, ev_esq, ev_ent;
    assign ev_ini = eventos[0];
    assign ev_dir = eventos[1];
    assign ev_esq = eventos[2];
    assign ev_ent = eventos[3];

    estado_t               estado_q, estado_d;
    logic [CURSOR_W-1:0]   cursor_q, cursor_d;
    logic [CURSOR_W-1:0]   cursor_max;
    logic [MODO-1:0]       modos_q, modos_d;
    logic [BPM-1:0]        bpm_q, bpm_d;
    logic [TOM-1:0]        tom_q, tom_d;
    logic [MUSICA-1:0]     musica_q, musica_d;

    // State, cursor and committed configuration; one-hot registers reset to bit 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            cursor_q <= '0;
            modos_q  <= MODO'(1);
            bpm_q    <= BPM'(1);
            tom_q    <= TOM'(1);
            musica_q <= MUSICA'(1);
        end else begin
            estado_q <= estado_d;
            cursor_q <= cursor_d;
            modos_q  <= modos_d;
            bpm_q    <= bpm_d;
            tom_q    <= tom_d;
            musica_q <= musica_d;
        end
    end

    // Last valid cursor index of the page currently shown.
    always_comb begin
        cursor_max = '0;
        case (estado_q)
            MENU_MODO:   cursor_max = CURSOR_W'(MODO - 1);
            MENU_BPM:    cursor_max = CURSOR_W'(BPM - 1);
            MENU_TOM:    cursor_max = CURSOR_W'(TOM - 1);
            MENU_MUSICA: cursor_max = CURSOR_W'(MUSICA - 1);
            default:     cursor_max = '0;
        endcase
    end

    // Next state: enter commits and advances (beating arrows), otherwise move cursor.
    always_comb begin
        estado_d = estado_q;
        cursor_d = cursor_q;
        modos_d  = modos_q;
        bpm_d    = bpm_q;
        tom_d    = tom_q;
        musica_d = musica_q;

        case (estado_q)
            OCIOSO: begin
                if (ev_ini) begin
                    estado_d = MENU_MODO;
                    cursor_d = onehot_para_indice(16'(modos_q));
                end
            end

            MENU_MODO, MENU_BPM, MENU_TOM, MENU_MUSICA: begin
                if (ev_ent) begin
                    case (estado_q)
                        MENU_MODO: begin
                            modos_d  = MODO'(1) << cursor_q;
                            estado_d = MENU_BPM;
                            cursor_d = onehot_para_indice(16'(bpm_q));
                        end
                        MENU_BPM: begin
                            bpm_d    = BPM'(1) << cursor_q;
                            estado_d = MENU_TOM;
                            cursor_d = onehot_para_indice(16'(tom_q));
                        end
                        MENU_TOM: begin
                            tom_d = TOM'(1) << cursor_q;
                            // Modes without a song page finish right after the tone.
                            if ((modos_q & MODOS_SEM_MUSICA) != '0) begin
                                estado_d = PRONTO;
                            end else begin
                                estado_d = MENU_MUSICA;
                                cursor_d = onehot_para_indice(16'(musica_q));
                            end
                        end
                        default: begin
                            musica_d = MUSICA'(1) << cursor_q;
                            estado_d = PRONTO;
                        end
                    endcase
                end else if (ev_dir && !ev_esq) begin
                    cursor_d = (cursor_q == cursor_max) ? '0 : cursor_q + 1'b1;
                end else if (ev_esq && !ev_dir) begin
                    cursor_d = (cursor_q == '0) ? cursor_max : cursor_q - 1'b1;
                end
            end

            PRONTO:  estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    assign menu_sel      = estado_q;
    assign mostra_menu   = (estado_q == MENU_MODO) || (estado_q == MENU_BPM) ||
                           (estado_q == MENU_TOM)  || (estado_q == MENU_MUSICA);
    assign config_pronta = (estado_q == PRONTO);
    assign arduino_out   = cursor_q;
    assign modos         = modos_q;
    assign bpm           = bpm_q;
    assign tom           = tom_q;
    assign musica        = musica_q;

endmodule

// File: tb/tb_controlador_menu.sv
// Directed bench for the configuration menu; inputs change and outputs are
// checked on the falling clock edge.
module tb_controlador_menu;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar_menu, right_arrow_pressed, left_arrow_pressed, enter_pressed;
    logic [2:0]  menu_sel;
    logic        mostra_menu;
    logic [3:0]  arduino_out;
    logic [5:0]  modos;
    logic [1:0]  bpm;
    logic [3:0]  tom;
    logic [15:0] musica;
    logic        config_pronta;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_INI  = 4'b0001;
    localparam logic [3:0] K_DIR  = 4'b0010;
    localparam logic [3:0] K_ESQ  = 4'b0100;
    localparam logic [3:0] K_ENT  = 4'b1000;

    always #5 clock = ~clock;

    controlador_menu dut (
        .clock               (clock),
        .reset               (reset),
        .iniciar_menu        (iniciar_menu),
        .right_arrow_pressed (right_arrow_pressed),
        .left_arrow_pressed  (left_arrow_pressed),
        .enter_pressed       (enter_pressed),
        .menu_sel            (menu_sel),
        .mostra_menu         (mostra_menu),
        .arduino_out         (arduino_out),
        .modos               (modos),
        .bpm                 (bpm),
        .tom                 (tom),
        .musica              (musica),
        .config_pronta       (config_pronta)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic drive(input logic [3:0] m);
        {enter_pressed, left_arrow_pressed, right_arrow_pressed, iniciar_menu} = m;
    endtask

    // Key(s) high for one cycle, then low for one cycle.
    task automatic press(input logic [3:0] m);
        drive(m);
        @(negedge clock);
        drive(K_NONE);
        @(negedge clock);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".menu_sel"}, 32'(menu_sel), 32'd0);
        chk({tag, ".mostra"},   32'(mostra_menu), 32'd0);
        chk({tag, ".cursor"},   32'(arduino_out), 32'd0);
        chk({tag, ".pronta"},   32'(config_pronta), 32'd0);
        chk({tag, ".modos"},    32'(modos), 32'h01);
        chk({tag, ".bpm"},      32'(bpm), 32'h1);
        chk({tag, ".tom"},      32'(tom), 32'h1);
        chk({tag, ".musica"},   32'(musica), 32'h0001);
    endtask

    initial begin
        reset = 1'b1;
        drive(K_NONE);
        repeat (2) @(negedge clock);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clock);

        // Idle ignores arrows and enter.
        press(K_DIR);
        press(K_ENT);
        chk("idle.menu_sel", 32'(menu_sel), 32'd0);
        chk("idle.cursor",   32'(arduino_out), 32'd0);
        chk("idle.modos",    32'(modos), 32'h01);

        // First pass: mode 2, bpm 1, tom 0, song 15.
        press(K_INI);
        chk("p1.start.sel",  32'(menu_sel), 32'd1);
        chk("p1.start.most", 32'(mostra_menu), 32'd1);
        press(K_INI);
        chk("p1.ini_ignored", 32'(menu_sel), 32'd1);
        press(K_DIR);
        press(K_DIR);
        chk("p1.cursor2",    32'(arduino_out), 32'd2);
        press(K_ENT);
        chk("p1.modos",      32'(modos), 32'h04);
        chk("p1.sel_bpm",    32'(menu_sel), 32'd2);
        chk("p1.bpm_cur0",   32'(arduino_out), 32'd0);
        press(K_ESQ);
        chk("p1.bpm_wrap",   32'(arduino_out), 32'd1);
        press(K_ENT);
        chk("p1.bpm",        32'(bpm), 32'h2);
        chk("p1.sel_tom",    32'(menu_sel), 32'd3);
        press(K_ENT);
        chk("p1.tom",        32'(tom), 32'h1);
        chk("p1.sel_mus",    32'(menu_sel), 32'd4);
        press(K_ESQ);
        chk("p1.mus_wrap",   32'(arduino_out), 32'd15);
        drive(K_ENT);
        @(negedge clock);
        chk("p1.musica",     32'(musica), 32'h8000);
        chk("p1.sel_pronto", 32'(menu_sel), 32'd5);
        chk("p1.pronta_hi",  32'(config_pronta), 32'd1);
        chk("p1.most_off",   32'(mostra_menu), 32'd0);
        drive(K_NONE);
        @(negedge clock);
        chk("p1.pronta_lo",  32'(config_pronta), 32'd0);
        chk("p1.sel_idle",   32'(menu_sel), 32'd0);

        // Second pass: cursors reload committed indices; pick mode 5 (skips song).
        press(K_INI);
        chk("p2.modo_load",  32'(arduino_out), 32'd2);
        press(K_ESQ);
        press(K_ESQ);
        press(K_ESQ);
        chk("p2.modo_wrap",  32'(arduino_out), 32'd5);
        press(K_ENT);
        chk("p2.modos",      32'(modos), 32'h20);
        chk("p2.bpm_load",   32'(arduino_out), 32'd1);
        press(K_ENT);
        chk("p2.bpm_keep",   32'(bpm), 32'h2);
        chk("p2.sel_tom",    32'(menu_sel), 32'd3);
        chk("p2.tom_load",   32'(arduino_out), 32'd0);
        drive(K_DIR);
        repeat (20) @(negedge clock);
        chk("p2.held_right", 32'(arduino_out), 32'd1);
        drive(K_NONE);
        @(negedge clock);
        press(K_DIR | K_ESQ);
        chk("p2.both_arrows", 32'(arduino_out), 32'd1);
        drive(K_ENT | K_DIR);
        @(negedge clock);
        chk("p2.tom_old_cur", 32'(tom), 32'h2);
        chk("p2.skip_sel",    32'(menu_sel), 32'd5);
        chk("p2.skip_pronta", 32'(config_pronta), 32'd1);
        chk("p2.musica_keep", 32'(musica), 32'h8000);
        drive(K_NONE);
        @(negedge clock);
        chk("p2.sel_idle",    32'(menu_sel), 32'd0);
        chk("p2.pronta_lo",   32'(config_pronta), 32'd0);

        // Reset mid-BPM page takes effect asynchronously.
        press(K_INI);
        press(K_ENT);
        chk("p3.sel_bpm",    32'(menu_sel), 32'd2);
        press(K_DIR);
        chk("p3.bpm_cur",    32'(arduino_out), 32'd0);
        reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Pass after reset starts from index 0 everywhere.
        press(K_INI);
        chk("p4.sel_modo",   32'(menu_sel), 32'd1);
        chk("p4.modo_load",  32'(arduino_out), 32'd0);
        press(K_ENT);
        chk("p4.modos",      32'(modos), 32'h01);
        chk("p4.bpm_load",   32'(arduino_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/controlador_menu.md
# controlador_menu

Configuration-menu sequencer for the music game. It walks the player through the mode, BPM, tone and song pages. Left/right arrows move a wrapping cursor and enter commits the choice into a one-hot configuration register. On completion it raises a one-cycle `config_pronta` for the game control unit. It sits between the keyboard/arrow inputs and the datapath's configuration registers, and drives `menu_sel`, `mostra_menu` and `arduino_out` for the external display.

## Interface
- `MODO`, 6, number of game modes (one-hot width)
- `BPM`, 2, number of tempo options
- `TOM`, 4, number of tone options
- `MUSICA`, 16, number of songs (max 16)
- `MODOS_SEM_MUSICA`, 6'b100000, mask of modes that skip the song page
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `iniciar_menu`  in  1  level; a rising edge starts the menu from idle
- `right_arrow_pressed`  in  1  level, synchronous, already debounced
- `left_arrow_pressed`  in  1  level, synchronous, already debounced
- `enter_pressed`  in  1  level, synchronous, already debounced
- `menu_sel`  out  3  current page: 0 idle, 1 modo, 2 bpm, 3 tom, 4 musica, 5 pronto
- `mostra_menu`  out  1  high on pages 1–4
- `arduino_out`  out  4  current cursor index
- `modos`  out  MODO  committed mode, one-hot
- `bpm`  out  BPM  committed tempo, one-hot
- `tom`  out  TOM  committed tone, one-hot
- `musica`  out  MUSICA  committed song, one-hot
- `config_pronta`  out  1  one-cycle pulse when configuration is complete

## Operation
- Rising-edge detection on `iniciar_menu` and on each arrow/enter input: event = in & ~in_q. A held key produces exactly one event.
- States: OCIOSO → MENU_MODO → MENU_BPM → MENU_TOM → MENU_MUSICA → PRONTO → OCIOSO.
- OCIOSO: an `iniciar_menu` edge goes to MENU_MODO. All arrow and enter events are ignored.
- Cursor on page entry loads the index of the currently committed one-hot bit for that page. Page size N is MODO, BPM, TOM or MUSICA.
- Cursor movement:
  - Right: cursor+1, wrapping N-1 → 0.
  - Left: cursor-1, wrapping 0 → N-1.
- Event priority within a cycle:
  - Enter beats arrows; arrows in that cycle are discarded.
  - Simultaneous left and right edges: no movement.
- Enter commits the cursor: page register ← (1 << cursor), then advance.
- Page skip: from MENU_TOM, if the committed `modos` & `MODOS_SEM_MUSICA` is nonzero, go straight to PRONTO and leave `musica` unchanged.
- PRONTO: `config_pronta`=1 for exactly one cycle, then OCIOSO. Registers hold until the next commit.
- `iniciar_menu` edges outside OCIOSO are ignored.
- Reset values:
  - State OCIOSO, cursor 0, `menu_sel`=0, `mostra_menu`=0, `config_pronta`=0, `arduino_out`=0.
  - `modos`, `bpm`, `tom` and `musica` each reset to bit 0 set (value 1).
  - All edge-detect registers clear.
- Reset asserted mid-menu returns everything to the reset values immediately, asynchronously. Uncommitted cursor movement is lost.
- One-hot registers are never all-zero and never have more than one bit set.

## Timing
- Input rises before edge k: the event is sampled at edge k, so cursor, state and registers change at edge k. Outputs are registered, visible one cycle after the input rise.
- Enter on the last page: PRONTO at edge k, `config_pronta` high from k to k+1, OCIOSO at edge k+1.
- Page transitions take one cycle. The cursor load for the new page happens on the same edge as the commit.
- Back-to-back events on consecutive cycles are each honoured; a key must drop for ≥1 cycle to re-trigger.

## Structure
- Shared package holds:
  - Page encodings (OCIOSO=0 … PRONTO=5) as localparams used by both this block and the control unit.
  - Cursor width constant (4).
- Sub-module `detector_borda`: a 1-bit rising-edge detector with async reset, instantiated 4×.
- One-hot → index conversion (for cursor load) is a function or priority loop inside the block; no sub-module.

## Test plan
- Reset, then hold: `modos`=6'b000001, `bpm`=2'b01, `tom`=4'b0001, `musica`=16'h0001, `menu_sel`=0.
- Start, right ×2, enter → `modos`=6'b000100, `menu_sel`=2. Then left once on BPM (cursor 0 → 1 wrap) and enter → `bpm`=2'b10.
- Full pass with mode 2 and song 15 (left once from 0) → `musica`=16'h8000, `config_pronta` pulses exactly 1 cycle, then `menu_sel`=0.
- Mode 5 selected → after the tom enter, `menu_sel` goes 3 → 5 directly and `musica` is unchanged.
- Right held 20 cycles → cursor +1 only. Left and right rising together → no change. Enter and right together → commit of the old cursor.
- Reset asserted mid-BPM page → all outputs at reset values the same cycle. A second menu pass starts with cursors loaded from the reset values (index 0).
